uart_resp_formatter: RTL and testbench
======================================

Name: uart_resp_formatter

Overview:
- Response-side counterpart of the command path: converts single-cycle response pulses from the command decoder into a byte stream for the UART transmitter.
- Frames 'K' (write ack), 'D' (read data) and 'E' (error) responses with their payload bytes.
- Sits between the register-file core outputs and uart_tx; one frame is in flight plus a one-deep pending slot.

Parameters:
- APPEND_EOL, 0, when 1 every frame ends with an extra 0x0A byte.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- resp_ok  input  1  1-cycle pulse: send 'K' frame
- resp_data  input  1  1-cycle pulse: send 'D' frame
- resp_err  input  1  1-cycle pulse: send 'E' frame
- resp_addr  input  8  address echoed in K/D frames; sampled with the pulse
- resp_data_byte  input  8  read data for D frame; sampled with the pulse
- resp_err_code  input  8  error code for E frame; sampled with the pulse
- tx_data  output  8  byte offered to uart_tx
- tx_valid  output  1  tx_data is valid; held until accepted
- tx_ready  input  1  uart_tx can accept; transfer when tx_valid && tx_ready
- busy  output  1  frame in flight or pending slot occupied
- drop  output  1  1-cycle pulse: a response was discarded (overflow)

Behaviour:
- Reset values: tx_valid=0, tx_data=0x00, busy=0, drop=0; active frame, pending slot, byte index and FSM cleared. Reset wins over every other event, including mid-frame, and the partial frame is abandoned.
- Frame formats, bytes in order:
  - K: 0x4B, addr.
  - D: 0x44, addr, data.
  - E: 0x45, err_code.
  - APPEND_EOL=1 adds 0x0A to each, so lengths are 2/3/2 or 3/4/3.
- Simultaneous pulses: priority err > data > ok. Only one frame is built and drop is not asserted.
- FSM has two states, IDLE and SEND.
  - IDLE: a pulse at cycle N loads the frame buffer, length and index=0. The FSM moves to SEND, with tx_valid=1 and tx_data=header at N+1.
  - SEND: tx_data=frame[idx] and tx_valid=1. The handshake advances idx and presents the next byte the following cycle. tx_data and tx_valid must not change while tx_valid && !tx_ready.
  - Last byte handshaken, pending slot full: load the pending frame the same cycle and stay in SEND. The new header appears next cycle, back-to-back with no bubble.
  - Last byte handshaken, pending slot empty, new pulse on the same cycle: load it directly as the active frame and stay in SEND.
  - Last byte handshaken otherwise: go to IDLE with tx_valid=0 next cycle.
- Pending slot:
  - A pulse arriving while in SEND, when not consumed as described above, is captured in the pending slot if it is empty.
  - If the slot is full, the pulse is discarded and drop=1 the next cycle. Active and pending frames are untouched.
- Payload is registered at pulse time. Later changes on resp_addr, resp_data_byte or resp_err_code never alter a captured frame.
- busy = (state==SEND) || pending_valid, registered.
- tx_ready is ignored while tx_valid=0.
- Index and length are 2-bit counters and never exceed length-1.

Test Plan:
- resp_ok, addr=0x03, tx_ready=1 constantly -> tx_data 0x4B then 0x03 on consecutive cycles starting one cycle after the pulse; then tx_valid=0 and busy=0.
- resp_data, addr=0x0F, data=0xA5, with tx_ready low for 3 cycles on each byte -> 0x44, 0x0F, 0xA5 each held stable until accepted; no byte skipped or repeated.
- resp_err, code=0x01 with APPEND_EOL=1 -> 0x45, 0x01, 0x0A.
- resp_ok(0x02) then resp_data(0x04, 0x7E) two cycles later, tx_ready=1 -> 0x4B, 0x02, 0x44, 0x04, 0x7E with no idle cycle between frames.
- Three pulses (ok 0x01, ok 0x02, err 0x03) on consecutive cycles with tx_ready=0 -> drop pulses once, for the third pulse. Releasing tx_ready yields exactly 0x4B 0x01 0x4B 0x02.
- rst asserted after the first byte of a D frame is accepted -> tx_valid=0 and busy=0 the next cycle. A subsequent resp_ok(0x05) yields a clean 0x4B, 0x05.

Source files
------------

// File: rtl/uart_resp_formatter.sv
// Turns single-cycle K/D/E response pulses into a byte stream for uart_tx.
// One frame is transmitted while at most one further response waits in a pending slot.
module uart_resp_formatter #(
  parameter bit APPEND_EOL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       resp_ok,
  input  logic       resp_data,
  input  logic       resp_err,
  input  logic [7:0] resp_addr,
  input  logic [7:0] resp_data_byte,
  input  logic [7:0] resp_err_code,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       drop
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state_q, state_d;
  logic [3:0][7:0] frame_q, frame_d;
  logic [1:0]      len_q, len_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0][7:0] pend_frame_q, pend_frame_d;
  logic [1:0]      pend_len_q, pend_len_d;
  logic            pend_valid_q, pend_valid_d;
  logic            drop_q, drop_d;
  logic            busy_q, busy_d;

  logic [3:0][7:0] new_frame;
  logic [1:0]      new_len;
  logic            pulse;
  logic            last_hs;
  logic [7:0]      eol;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      frame_q      <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      pend_frame_q <= '0;
      pend_len_q   <= '0;
      pend_valid_q <= 1'b0;
      drop_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      pend_frame_q <= pend_frame_d;
      pend_len_q   <= pend_len_d;
      pend_valid_q <= pend_valid_d;
      drop_q       <= drop_d;
      busy_q       <= busy_d;
    end
  end

  // Frame built from the pulse in priority order err > data > ok; len holds length-1.
  always_comb begin
    eol       = APPEND_EOL ? 8'h0A : 8'h00;
    new_frame = '0;
    new_len   = 2'd0;
    if (resp_err) begin
      new_frame = {8'h00, eol, resp_err_code, 8'h45};
      new_len   = APPEND_EOL ? 2'd2 : 2'd1;
    end else if (resp_data) begin
      new_frame = {eol, resp_data_byte, resp_addr, 8'h44};
      new_len   = APPEND_EOL ? 2'd3 : 2'd2;
    end else if (resp_ok) begin
      new_frame = {8'h00, eol, resp_addr, 8'h4B};
      new_len   = APPEND_EOL ? 2'd2 : 2'd1;
    end
  end

  always_comb begin
    pulse        = resp_ok | resp_data | resp_err;
    last_hs      = tx_ready && (idx_q == len_q);
    state_d      = state_q;
    frame_d      = frame_q;
    len_d        = len_q;
    idx_d        = idx_q;
    pend_frame_d = pend_frame_q;
    pend_len_d   = pend_len_q;
    pend_valid_d = pend_valid_q;
    drop_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (pulse) begin
          frame_d = new_frame;
          len_d   = new_len;
          idx_d   = 2'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (last_hs) begin
          // The pending slot is still occupied this cycle, so a coincident pulse overflows.
          if (pend_valid_q) begin
            frame_d      = pend_frame_q;
            len_d        = pend_len_q;
            idx_d        = 2'd0;
            pend_valid_d = 1'b0;
            drop_d       = pulse;
          end else if (pulse) begin
            frame_d = new_frame;
            len_d   = new_len;
            idx_d   = 2'd0;
          end else begin
            idx_d   = 2'd0;
            state_d = IDLE;
          end
        end else begin
          if (tx_ready) begin
            idx_d = idx_q + 2'd1;
          end
          if (pulse) begin
            if (pend_valid_q) begin
              drop_d = 1'b1;
            end else begin
              pend_frame_d = new_frame;
              pend_len_d   = new_len;
              pend_valid_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SEND) || pend_valid_d;
  end

  always_comb begin
    tx_valid = (state_q == SEND);
    tx_data  = (state_q == SEND) ? frame_q[idx_q] : 8'h00;
    busy     = busy_q;
    drop     = drop_q;
  end

endmodule

// File: tb/tb_uart_resp_formatter.sv
// Self-checking bench: two instances (without and with end-of-line byte) share stimulus,
// and a per-instance scoreboard queue is compared against every handshaken byte.
module tb_uart_resp_formatter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       resp_ok = 1'b0, resp_data = 1'b0, resp_err = 1'b0;
  logic [7:0] resp_addr = 8'h00, resp_data_byte = 8'h00, resp_err_code = 8'h00;
  logic       tx_ready = 1'b0;

  logic [7:0] tx_data0, tx_data1;
  logic       tx_valid0, tx_valid1, busy0, busy1, drop0, drop1;

  int vecs = 0;
  int errs = 0;
  int drop_cnt0 = 0;
  int drop_cnt1 = 0;
  logic [7:0] exp0[$];
  logic [7:0] exp1[$];
  logic       hold0 = 1'b0, hold1 = 1'b0;
  logic [7:0] hd0 = 8'h00, hd1 = 8'h00;

  typedef struct {
    logic       ok, dat, err;
    logic [7:0] addr, db, code;
    logic [7:0] b0, b1, b2;
    int         n;
  } vec_t;
  vec_t tbl[6];

  uart_resp_formatter #(.APPEND_EOL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .resp_ok(resp_ok), .resp_data(resp_data), .resp_err(resp_err),
    .resp_addr(resp_addr), .resp_data_byte(resp_data_byte), .resp_err_code(resp_err_code),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready), .busy(busy0), .drop(drop0)
  );

  uart_resp_formatter #(.APPEND_EOL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .resp_ok(resp_ok), .resp_data(resp_data), .resp_err(resp_err),
    .resp_addr(resp_addr), .resp_data_byte(resp_data_byte), .resp_err_code(resp_err_code),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready), .busy(busy1), .drop(drop1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    vecs++;
    if (act !== expv) begin
      errs++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Scoreboard and hold-stability monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (rst) begin
      hold0 = 1'b0;
      hold1 = 1'b0;
    end else begin
      if (drop0) drop_cnt0++;
      if (drop1) drop_cnt1++;
      if (hold0) begin
        checkOutput("hold0_valid", {31'd0, tx_valid0}, 32'd1);
        checkOutput("hold0_data", {24'd0, tx_data0}, {24'd0, hd0});
      end
      if (hold1) begin
        checkOutput("hold1_valid", {31'd0, tx_valid1}, 32'd1);
        checkOutput("hold1_data", {24'd0, tx_data1}, {24'd0, hd1});
      end
      if (tx_valid0 && tx_ready) begin
        if (exp0.size() == 0) checkOutput("sb0_extra_byte", {24'd0, tx_data0}, 32'hFFFF_FFFF);
        else checkOutput("sb0_byte", {24'd0, tx_data0}, {24'd0, exp0.pop_front()});
      end
      if (tx_valid1 && tx_ready) begin
        if (exp1.size() == 0) checkOutput("sb1_extra_byte", {24'd0, tx_data1}, 32'hFFFF_FFFF);
        else checkOutput("sb1_byte", {24'd0, tx_data1}, {24'd0, exp1.pop_front()});
      end
      hold0 = tx_valid0 && !tx_ready;
      hold1 = tx_valid1 && !tx_ready;
      hd0   = tx_data0;
      hd1   = tx_data1;
    end
  end

  task automatic pushFrame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input int n);
    logic [7:0] bytes[3];
    bytes[0] = b0;
    bytes[1] = b1;
    bytes[2] = b2;
    for (int i = 0; i < n; i++) begin
      exp0.push_back(bytes[i]);
      exp1.push_back(bytes[i]);
    end
    exp1.push_back(8'h0A);
  endtask

  // Called just after a rising edge; the pulse is held across exactly one rising edge.
  task automatic applyStimulus(input logic ok, input logic dat, input logic err,
                               input logic [7:0] addr, input logic [7:0] db, input logic [7:0] code);
    resp_ok        = ok;
    resp_data      = dat;
    resp_err       = err;
    resp_addr      = addr;
    resp_data_byte = db;
    resp_err_code  = code;
    @(posedge clk); #1;
    resp_ok        = 1'b0;
    resp_data      = 1'b0;
    resp_err       = 1'b0;
    resp_addr      = 8'($urandom);
    resp_data_byte = 8'($urandom);
    resp_err_code  = 8'($urandom);
  endtask

  task automatic waitDrain(input string name);
    int i;
    for (i = 0; i < 80; i++) begin
      @(negedge clk);
      if (exp0.size() == 0 && exp1.size() == 0 && !busy0 && !busy1) break;
    end
    checkOutput({name, "_drained"}, {31'd0, (exp0.size() == 0 && exp1.size() == 0 && !busy0 && !busy1)}, 32'd1);
    checkOutput({name, "_idle_valid0"}, {31'd0, tx_valid0}, 32'd0);
    checkOutput({name, "_idle_valid1"}, {31'd0, tx_valid1}, 32'd0);
    exp0.delete();
    exp1.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    tbl[0] = '{ok:1, dat:0, err:0, addr:8'h03, db:8'h00, code:8'h00, b0:8'h4B, b1:8'h03, b2:8'h00, n:2};
    tbl[1] = '{ok:0, dat:1, err:0, addr:8'h0F, db:8'hA5, code:8'h00, b0:8'h44, b1:8'h0F, b2:8'hA5, n:3};
    tbl[2] = '{ok:0, dat:0, err:1, addr:8'h00, db:8'h00, code:8'h01, b0:8'h45, b1:8'h01, b2:8'h00, n:2};
    tbl[3] = '{ok:1, dat:1, err:0, addr:8'h10, db:8'h20, code:8'h99, b0:8'h44, b1:8'h10, b2:8'h20, n:3};
    tbl[4] = '{ok:1, dat:1, err:1, addr:8'h11, db:8'h22, code:8'h7F, b0:8'h45, b1:8'h7F, b2:8'h00, n:2};
    tbl[5] = '{ok:1, dat:0, err:1, addr:8'hFF, db:8'h33, code:8'h00, b0:8'h45, b1:8'h00, b2:8'h00, n:2};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_valid0", {31'd0, tx_valid0}, 32'd0);
    checkOutput("rst_data0", {24'd0, tx_data0}, 32'h00);
    checkOutput("rst_busy0", {31'd0, busy0}, 32'd0);
    checkOutput("rst_drop0", {31'd0, drop0}, 32'd0);
    checkOutput("rst_valid1", {31'd0, tx_valid1}, 32'd0);
    checkOutput("rst_busy1", {31'd0, busy1}, 32'd0);
    @(posedge clk); #1;

    // Single frames with a always-ready transmitter, including priority resolution.
    tx_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      pushFrame(tbl[v].b0, tbl[v].b1, tbl[v].b2, tbl[v].n);
      applyStimulus(tbl[v].ok, tbl[v].dat, tbl[v].err, tbl[v].addr, tbl[v].db, tbl[v].code);
      @(negedge clk);
      checkOutput("first_byte0", {23'd0, tx_valid0, tx_data0}, {23'd1, tbl[v].b0});
      @(posedge clk); #1;
      waitDrain("table");
    end

    // D frame with the transmitter stalling three cycles on every byte.
    pushFrame(8'h44, 8'h0F, 8'hA5, 3);
    tx_ready = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h0F, 8'hA5, 8'h00);
    for (int b = 0; b < 4; b++) begin
      repeat (3) begin @(posedge clk); #1; end
      tx_ready = 1'b1;
      @(posedge clk); #1;
      tx_ready = 1'b0;
    end
    tx_ready = 1'b1;
    waitDrain("stall");

    // Back-to-back frames: second pulse two cycles after the first.
    pushFrame(8'h4B, 8'h02, 8'h00, 2);
    pushFrame(8'h44, 8'h04, 8'h7E, 3);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h02, 8'h00, 8'h00);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h04, 8'h7E, 8'h00);
    @(negedge clk);
    checkOutput("b2b_no_gap0", {23'd0, tx_valid0, tx_data0}, {23'd1, 8'h44});
    @(posedge clk); #1;
    waitDrain("b2b");

    // Overflow: third pulse while active and pending are both occupied.
    tx_ready = 1'b0;
    pushFrame(8'h4B, 8'h01, 8'h00, 2);
    pushFrame(8'h4B, 8'h02, 8'h00, 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h01, 8'h00, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h02, 8'h00, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h03);
    @(negedge clk);
    checkOutput("ovf_drop0", {31'd0, drop0}, 32'd1);
    checkOutput("ovf_drop1", {31'd0, drop1}, 32'd1);
    checkOutput("ovf_busy0", {31'd0, busy0}, 32'd1);
    repeat (3) begin @(posedge clk); #1; end
    tx_ready = 1'b1;
    waitDrain("ovf");

    // Reset in the middle of a D frame, then a clean K frame.
    exp0.push_back(8'h44);
    exp1.push_back(8'h44);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h0F, 8'hA5, 8'h00);
    @(posedge clk); #1;
    rst      = 1'b1;
    tx_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("midrst_valid0", {31'd0, tx_valid0}, 32'd0);
    checkOutput("midrst_busy0", {31'd0, busy0}, 32'd0);
    checkOutput("midrst_valid1", {31'd0, tx_valid1}, 32'd0);
    checkOutput("midrst_busy1", {31'd0, busy1}, 32'd0);
    checkOutput("midrst_header_taken", exp0.size(), 32'd0);
    @(posedge clk); #1;
    rst      = 1'b0;
    tx_ready = 1'b1;
    pushFrame(8'h4B, 8'h05, 8'h00, 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h05, 8'h00, 8'h00);
    waitDrain("postrst");

    checkOutput("drop_total0", drop_cnt0, 32'd1);
    checkOutput("drop_total1", drop_cnt1, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
